// File: rtl/reg_bank_if.sv
// Register bank access bundle: decode-side read addresses and
// write-back port in one direction, read data in the other.
//   master: drives RA, RB, WC, WPC, W_RB; receives PRA, PRB
//   slave : receives RA, RB, WC, WPC, W_RB; drives PRA, PRB
interface reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [ADDR_W-1:0] WC;
    logic [DATA_W-1:0] WPC;
    logic              W_RB;
    logic [DATA_W-1:0] PRA;
    logic [DATA_W-1:0] PRB;

    modport master (
        output RA, RB, WC, WPC, W_RB,
        input  PRA, PRB
    );

    modport slave (
        input  RA, RB, WC, WPC, W_RB,
        output PRA, PRB
    );
endinterface

// File: rtl/reg_bank.sv
// General-purpose register file: 2**ADDR_W x DATA_W, two async
// read ports (PRA/PRB), one write port clocked on CLK rising edge.
// Ports: CLK clock; RESET async active-low clear of all registers;
//        bus (reg_bank_if.slave) carries RA/RB/WC/WPC/W_RB/PRA/PRB.
// Option: REG_BANK_BYPASS_EN forwards WPC to a read port whose
//         address matches WC while W_RB=1 (suppressed in reset).
module reg_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    reg_bank_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.W_RB) begin
            regs[bus.WC] <= bus.WPC;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forward in-flight write data so decode sees it this cycle.
    always_comb begin
        fwd_a = RESET && bus.W_RB && (bus.RA == bus.WC);
        fwd_b = RESET && bus.W_RB && (bus.RB == bus.WC);
        bus.PRA = fwd_a ? bus.WPC : regs[bus.RA];
        bus.PRB = fwd_b ? bus.WPC : regs[bus.RB];
    end
`else
    always_comb begin
        bus.PRA = regs[bus.RA];
        bus.PRB = regs[bus.RB];
    end
`endif
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand
// sequences for reset and write/read timing, and random traffic.
module tb_reg_bank;
    logic clk;
    logic rst_n;

    int checks;
    int failures;

    logic [31:0] model [16];

    typedef struct {
        logic [3:0]  wc;
        logic [31:0] wpc;
        logic        we;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    reg_bank_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    reg_bank #(.DATA_W(32), .ADDR_W(4)) u_dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.WC   = a;
        bus.WPC  = d;
        bus.W_RB = 1'b1;
        @(posedge clk);
        #1;
        bus.W_RB = 1'b0;
        model[a] = d;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            bus.RA = 4'(i);
            bus.RB = 4'(15 - i);
            #1;
            check(name, bus.PRA, 32'h0);
            check(name, bus.PRB, 32'h0);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.RA   = '0;
        bus.RB   = '0;
        bus.WC   = '0;
        bus.WPC  = '0;
        bus.W_RB = 1'b0;
        clear_model();

        vecs[0] = '{4'd5,  32'hDEADBEEF, 1'b1, 4'd5,  4'd0,
                    32'hDEADBEEF, 32'h0};
        vecs[1] = '{4'd5,  32'h12345678, 1'b0, 4'd5,  4'd5,
                    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{4'd0,  32'hFFFFFFFF, 1'b1, 4'd0,  4'd5,
                    32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[3] = '{4'd7,  32'hA5A5A5A5, 1'b1, 4'd7,  4'd7,
                    32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{4'd3,  32'h11111111, 1'b1, 4'd3,  4'd0,
                    32'h11111111, 32'hFFFFFFFF};
        vecs[5] = '{4'd15, 32'hCAFEF00D, 1'b1, 4'd15, 4'd14,
                    32'hCAFEF00D, 32'h0};

        // Reset state, then writes ignored while held in reset.
        #2;
        sweep_zero("reset_init");
        @(negedge clk);
        bus.WC   = 4'd9;
        bus.WPC  = 32'h55AA55AA;
        bus.W_RB = 1'b1;
        bus.RA   = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        check("write_in_reset", bus.PRA, 32'h0);
        @(negedge clk);
        bus.W_RB = 1'b0;
        rst_n    = 1'b1;
        #1;
        sweep_zero("after_release");

        // Directed vector table.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            bus.WC   = vecs[v].wc;
            bus.WPC  = vecs[v].wpc;
            bus.W_RB = vecs[v].we;
            @(posedge clk);
            #1;
            bus.W_RB = 1'b0;
            if (vecs[v].we) model[vecs[v].wc] = vecs[v].wpc;
            bus.RA = vecs[v].ra;
            bus.RB = vecs[v].rb;
            #1;
            check($sformatf("vec%0d_pra", v), bus.PRA, vecs[v].exp_a);
            check($sformatf("vec%0d_prb", v), bus.PRB, vecs[v].exp_b);
        end

        // Same-cycle read of the register being written.
        @(negedge clk);
        bus.RA   = 4'd3;
        bus.RB   = 4'd3;
        bus.WC   = 4'd3;
        bus.WPC  = 32'h22222222;
        bus.W_RB = 1'b1;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("bypass_pre_a", bus.PRA, 32'h22222222);
        check("bypass_pre_b", bus.PRB, 32'h22222222);
`else
        check("bypass_pre_a", bus.PRA, 32'h11111111);
        check("bypass_pre_b", bus.PRB, 32'h11111111);
`endif
        @(posedge clk);
        #1;
        bus.W_RB = 1'b0;
        model[3] = 32'h22222222;
        #1;
        check("bypass_post_a", bus.PRA, 32'h22222222);
        check("bypass_post_b", bus.PRB, 32'h22222222);

        // Fill and read back, five random data sets.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 16; i++) write_reg(4'(i), $urandom);
            for (int i = 0; i < 15; i++) begin
                bus.RA = 4'(i);
                bus.RB = 4'(i + 1);
                #1;
                check("fill_pra", bus.PRA, model[i]);
                check("fill_prb", bus.PRB, model[i + 1]);
            end
        end

        // Random mixed traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] exp_a;
            logic [31:0] exp_b;
            @(negedge clk);
            bus.WC   = 4'($urandom_range(0, 15));
            bus.WPC  = $urandom;
            bus.W_RB = 1'($urandom_range(0, 1));
            bus.RA   = 4'($urandom_range(0, 15));
            bus.RB   = 4'($urandom_range(0, 15));
            #1;
            exp_a = model[bus.RA];
            exp_b = model[bus.RB];
`ifdef REG_BANK_BYPASS_EN
            if (bus.W_RB && bus.RA == bus.WC) exp_a = bus.WPC;
            if (bus.W_RB && bus.RB == bus.WC) exp_b = bus.WPC;
`endif
            check("rand_pre_a", bus.PRA, exp_a);
            check("rand_pre_b", bus.PRB, exp_b);
            @(posedge clk);
            if (bus.W_RB) model[bus.WC] = bus.WPC;
            #1;
            check("rand_post_a", bus.PRA, model[bus.RA]);
            check("rand_post_b", bus.PRB, model[bus.RB]);
        end

        // Asynchronous reset mid-cycle with non-zero contents.
        @(negedge clk);
        bus.W_RB = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (model[i] == 32'h0) write_reg(4'(i), 32'h1 + 32'(i));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        sweep_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep_zero("reset_release");

        // First write right after release lands.
        write_reg(4'd12, 32'h0BADF00D);
        bus.RA = 4'd12;
        bus.RB = 4'd11;
        #1;
        check("first_write_a", bus.PRA, 32'h0BADF00D);
        check("first_write_b", bus.PRB, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register file for the processor datapath: sixteen 32-bit registers with two independent combinational read ports (PRA, PRB) and one clocked write port. Decode drives the read addresses RA/RB for operand fetch; write-back drives WC, WPC and W_RB.

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 4: address width in bits. Register count is 2**ADDR_W (16).

Ports:
- CLK  in  1  system clock; all writes occur on its rising edge.
- RESET  in  1  reset, asynchronous, active-low; clears every register.
- RA  in  ADDR_W  read address, port A.
- RB  in  ADDR_W  read address, port B.
- WC  in  ADDR_W  write address.
- WPC  in  DATA_W  write data.
- W_RB  in  1  write enable, active-high.
- PRA  out  DATA_W  contents of register RA.
- PRB  out  DATA_W  contents of register RB.

## Operation
- Storage: array of 2**ADDR_W registers, each DATA_W bits. Every register, including register 0, is writable and readable. There is no hard-wired zero.
- Write: at a CLK rising edge with W_RB=1 and RESET=1, reg[WC] <= WPC. With W_RB=0, all registers hold their values.
- Read: PRA = reg[RA] and PRB = reg[RB]. Both are purely combinational, independent of CLK and W_RB. RA=RB is legal; both outputs then show the same register.
- Reset: while RESET=0, all registers are 0. As a result PRA=PRB=0 for any address. Writes are ignored during reset.
- Addresses are full-range. There are no out-of-range addresses and no wrap-around logic.

## Timing
- Write latency: one edge. Data presented with WC/W_RB before a rising edge is stored at that edge. The new value appears on PRA/PRB (when addressed) after combinational delay following the edge.
- Read latency: zero cycles. Outputs follow changes in RA/RB and register contents combinationally.
- Same-cycle read of a register being written: without the bypass option, PRA/PRB show the old value until the edge and the new value after it.
- Reset is asserted asynchronously and takes effect immediately, mid-cycle included.
- Reset release is synchronised by the user. The first write can occur on the first rising edge with RESET=1.
- WC/WPC/W_RB changing between edges has no effect. Only the values present at the rising edge matter.

## Configuration
- REG_BANK_BYPASS_EN defined:
  - Write-to-read forwarding is enabled.
  - If W_RB=1 and RA==WC, then PRA=WPC combinationally. The same rule applies to PRB with RB==WC.
  - Forwarding is suppressed while RESET=0.
- REG_BANK_BYPASS_EN undefined:
  - No forwarding. PRA/PRB always show stored contents.
  - Default build.

## Test plan
- Reset: drive RESET=0 with arbitrary register contents, then sweep RA/RB over 0..15. Required: PRA=PRB=32'h0 for every address. Release RESET and confirm the registers are still 0.
- Fill and read back: with W_RB=1, write a random 32-bit value to each WC=0..15 on successive rising edges, then set W_RB=0. Read with RA=i and RB=i+1 for i=0..14. Required: PRA=value[i] and PRB=value[i+1]. Repeat for 5 random data sets.
- Write enable: write 32'hDEADBEEF to reg 5, then present WC=5, WPC=32'h12345678 with W_RB=0 for one edge. Required: PRA (RA=5) stays 32'hDEADBEEF.
- Register 0 writable: write 32'hFFFFFFFF to WC=0. Required: PRA with RA=0 reads 32'hFFFFFFFF.
- Dual-port same address: RA=RB=7 after writing 32'hA5A5A5A5 to reg 7. Required: PRA=PRB=32'hA5A5A5A5.
- Bypass: reg 3 holds 32'h11111111; set W_RB=1, WC=3, WPC=32'h22222222, RA=3 before the edge. Required:
  - With REG_BANK_BYPASS_EN, PRA=32'h22222222 before the edge.
  - Without it, PRA=32'h11111111 before the edge.
  - In both builds, PRA=32'h22222222 after the edge.
